// File: rtl/des_key_mix.sv
// DES round front end: expands the right half-block with table E, mixes in the round
// subkey, and tags each word with its round index through a two-stage elastic pipeline.
module des_key_mix #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [32:1] IN_R,
    input  logic [48:1] IN_K,
    input  logic        IN_FIRST,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [48:1] OUT_X,
    output logic [3:0]  OUT_ROUND,
    output logic        OUT_LAST,
    output logic        SEQ_ERR
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    logic        r_a_valid;
    logic [48:1] r_a_x;
    logic [3:0]  r_a_round;
    logic        r_b_valid;
    logic [48:1] r_b_x;
    logic [3:0]  r_b_round;
    logic        r_b_last;
    logic [3:0]  r_rc;
    logic        r_seq_err;

    logic        w_load_b;
    logic        w_accept;
    logic [3:0]  w_tag;
    logic [48:1] w_e;
    logic [48:1] w_x;

    // Table E; IN_R[33-n] is FIPS bit n and the MSB of w_e is FIPS output bit 1.
    assign w_e = {IN_R[1],  IN_R[32], IN_R[31], IN_R[30], IN_R[29], IN_R[28],
                  IN_R[29], IN_R[28], IN_R[27], IN_R[26], IN_R[25], IN_R[24],
                  IN_R[25], IN_R[24], IN_R[23], IN_R[22], IN_R[21], IN_R[20],
                  IN_R[21], IN_R[20], IN_R[19], IN_R[18], IN_R[17], IN_R[16],
                  IN_R[17], IN_R[16], IN_R[15], IN_R[14], IN_R[13], IN_R[12],
                  IN_R[13], IN_R[12], IN_R[11], IN_R[10], IN_R[9],  IN_R[8],
                  IN_R[9],  IN_R[8],  IN_R[7],  IN_R[6],  IN_R[5],  IN_R[4],
                  IN_R[5],  IN_R[4],  IN_R[3],  IN_R[2],  IN_R[1],  IN_R[32]};

    assign w_x      = w_e ^ IN_K;
    assign w_load_b = !r_b_valid || OUT_READY;
    assign IN_READY = !r_a_valid || w_load_b;
    assign w_accept = IN_VALID && IN_READY;
    assign w_tag    = IN_FIRST ? 4'd0 : r_rc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_a_valid <= 1'b0;
            r_a_x     <= '0;
            r_a_round <= '0;
        end else if (w_accept) begin
            r_a_valid <= 1'b1;
            r_a_x     <= w_x;
            r_a_round <= w_tag;
        end else if (w_load_b) begin
            r_a_valid <= 1'b0;
        end
    end

    // Stage B holds while the downstream stalls, keeping the outputs stable.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_b_valid <= 1'b0;
            r_b_x     <= '0;
            r_b_round <= '0;
            r_b_last  <= 1'b0;
        end else if (w_load_b) begin
            r_b_valid <= r_a_valid;
            if (r_a_valid) begin
                r_b_x     <= r_a_x;
                r_b_round <= r_a_round;
                r_b_last  <= (r_a_round == LAST_ROUND);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rc      <= '0;
            r_seq_err <= 1'b0;
        end else if (w_accept) begin
            r_rc <= (w_tag == LAST_ROUND) ? 4'd0 : w_tag + 4'd1;
            if ((IN_FIRST && r_rc != 4'd0) || (!IN_FIRST && r_rc == 4'd0))
                r_seq_err <= 1'b1;
        end
    end

    assign OUT_VALID = r_b_valid;
    assign OUT_X     = r_b_x;
    assign OUT_ROUND = r_b_round;
    assign OUT_LAST  = r_b_last;
    assign SEQ_ERR   = r_seq_err;

endmodule

// File: tb/tb_des_key_mix.sv
// Directed-vector bench for des_key_mix: FIPS expansion vectors, round tagging,
// backpressure, sequencing errors and mid-flight reset.
module tb_des_key_mix;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [32:1] IN_R = '0;
    logic [48:1] IN_K = '0;
    logic        IN_FIRST = 1'b0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic [48:1] OUT_X;
    logic [3:0]  OUT_ROUND;
    logic        OUT_LAST;
    logic        SEQ_ERR;

    int n_vec = 0;
    int n_err = 0;

    des_key_mix #(.NUM_ROUNDS(16)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_R(IN_R), .IN_K(IN_K), .IN_FIRST(IN_FIRST),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_X(OUT_X), .OUT_ROUND(OUT_ROUND), .OUT_LAST(OUT_LAST),
        .SEQ_ERR(SEQ_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [32:1] r, input logic [48:1] k, input logic f);
        IN_VALID = v;
        IN_R     = r;
        IN_K     = k;
        IN_FIRST = f;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, '0, 1'b0);
        OUT_READY = 1'b1;
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #2;
        n_vec++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", OUT_VALID); end
        n_vec++; if (OUT_X !== 48'h0) begin n_err++; $display("FAIL reset_out_x: got %h want 0", OUT_X); end
        n_vec++; if (OUT_ROUND !== 4'd0 || OUT_LAST !== 1'b0) begin n_err++; $display("FAIL reset_round_last: got %0d/%b want 0/0", OUT_ROUND, OUT_LAST); end
        n_vec++; if (SEQ_ERR !== 1'b0) begin n_err++; $display("FAIL reset_seq_err: got %b want 0", SEQ_ERR); end
        n_vec++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", IN_READY); end
        step();
        RST = 1'b0;
    endtask

    task automatic test_fips_vector();
        do_reset();
        drive(1'b1, 32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        n_vec++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL fips_latency1: out_valid %b want 0", OUT_VALID); end
        step();
        n_vec++; if (OUT_VALID !== 1'b1) begin n_err++; $display("FAIL fips_latency2: out_valid %b want 1", OUT_VALID); end
        n_vec++; if (OUT_X !== 48'h6117BA866527) begin n_err++; $display("FAIL fips_x: got %h want 6117ba866527", OUT_X); end
        n_vec++; if (OUT_X[42:37] !== 6'b010001) begin n_err++; $display("FAIL fips_s2: got %b want 010001", OUT_X[42:37]); end
        n_vec++; if (OUT_ROUND !== 4'd0 || OUT_LAST !== 1'b0) begin n_err++; $display("FAIL fips_round: got %0d/%b want 0/0", OUT_ROUND, OUT_LAST); end
        step();
        n_vec++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL fips_drain: out_valid %b want 0", OUT_VALID); end
    endtask

    task automatic test_extremes();
        logic [48:1] exp_x [4];
        exp_x[0] = 48'hFFFFFFFFFFFF;
        exp_x[1] = 48'hFFFFFFFFFFFF;
        exp_x[2] = 48'h400000000001;
        exp_x[3] = 48'h800000000002;
        do_reset();
        for (int s = 1; s <= 5; s++) begin
            case (s)
                1: drive(1'b1, 32'hFFFFFFFF, 48'h0, 1'b1);
                2: drive(1'b1, 32'h0, 48'hFFFFFFFFFFFF, 1'b0);
                3: drive(1'b1, 32'h80000000, 48'h0, 1'b0);
                4: drive(1'b1, 32'h00000001, 48'h0, 1'b0);
                default: drive(1'b0, '0, '0, 1'b0);
            endcase
            step();
            if (s >= 2) begin
                n_vec++;
                if (OUT_VALID !== 1'b1 || OUT_X !== exp_x[s-2] || OUT_ROUND !== 4'(s-2)) begin
                    n_err++;
                    $display("FAIL extreme_word%0d: got v=%b x=%h r=%0d want v=1 x=%h r=%0d",
                             s-2, OUT_VALID, OUT_X, OUT_ROUND, exp_x[s-2], s-2);
                end
            end
        end
        n_vec++; if (SEQ_ERR !== 1'b0) begin n_err++; $display("FAIL extreme_seq_err: got %b want 0", SEQ_ERR); end
    endtask

    task automatic test_back_to_back();
        logic [48:1] k;
        do_reset();
        for (int s = 1; s <= 17; s++) begin
            if (s <= 16) begin
                k = 48'(s-1) * 48'h111111111111;
                drive(1'b1, 32'h0, k, s == 1);
                n_vec++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready%0d: got %b want 1", s-1, IN_READY); end
            end else begin
                drive(1'b0, '0, '0, 1'b0);
            end
            step();
            if (s >= 2) begin
                k = 48'(s-2) * 48'h111111111111;
                n_vec++;
                if (OUT_VALID !== 1'b1 || OUT_ROUND !== 4'(s-2) || OUT_LAST !== (s == 17) || OUT_X !== k) begin
                    n_err++;
                    $display("FAIL b2b_word%0d: got v=%b r=%0d last=%b x=%h want v=1 r=%0d last=%b x=%h",
                             s-2, OUT_VALID, OUT_ROUND, OUT_LAST, OUT_X, s-2, s == 17, k);
                end
            end
        end
        n_vec++; if (SEQ_ERR !== 1'b0) begin n_err++; $display("FAIL b2b_seq_err: got %b want 0", SEQ_ERR); end
    endtask

    task automatic test_backpressure();
        do_reset();
        OUT_READY = 1'b0;
        drive(1'b1, 32'h0, 48'h00000000000A, 1'b1);
        step();
        drive(1'b1, 32'h0, 48'h00000000000B, 1'b0);
        n_vec++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL bp_ready_second: got %b want 1", IN_READY); end
        step();
        drive(1'b1, 32'h0, 48'h00000000000C, 1'b0);
        n_vec++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL bp_ready_full: got %b want 0", IN_READY); end
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (OUT_VALID !== 1'b1 || OUT_X !== 48'hA || OUT_ROUND !== 4'd0 || IN_READY !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v=%b x=%h r=%0d rdy=%b want v=1 x=a r=0 rdy=0",
                         c, OUT_VALID, OUT_X, OUT_ROUND, IN_READY);
            end
            step();
        end
        OUT_READY = 1'b1;
        #1;
        n_vec++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL bp_ready_release: got %b want 1", IN_READY); end
        step();
        drive(1'b0, '0, '0, 1'b0);
        n_vec++; if (OUT_VALID !== 1'b1 || OUT_X !== 48'hB || OUT_ROUND !== 4'd1) begin n_err++; $display("FAIL bp_word1: got v=%b x=%h r=%0d want v=1 x=b r=1", OUT_VALID, OUT_X, OUT_ROUND); end
        step();
        n_vec++; if (OUT_VALID !== 1'b1 || OUT_X !== 48'hC || OUT_ROUND !== 4'd2) begin n_err++; $display("FAIL bp_word2: got v=%b x=%h r=%0d want v=1 x=c r=2", OUT_VALID, OUT_X, OUT_ROUND); end
        step();
        n_vec++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL bp_no_dup: out_valid %b want 0", OUT_VALID); end
    endtask

    task automatic test_seq_err();
        logic [3:0] exp_round [6];
        exp_round = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
        do_reset();
        for (int s = 1; s <= 7; s++) begin
            if (s <= 6) drive(1'b1, 32'h0, 48'(s), (s == 1) || (s == 5));
            else        drive(1'b0, '0, '0, 1'b0);
            step();
            n_vec++; if (SEQ_ERR !== (s >= 5)) begin n_err++; $display("FAIL seq_err_flag%0d: got %b want %b", s, SEQ_ERR, s >= 5); end
            if (s >= 2) begin
                n_vec++;
                if (OUT_VALID !== 1'b1 || OUT_ROUND !== exp_round[s-2] || OUT_X !== 48'(s-1)) begin
                    n_err++;
                    $display("FAIL seq_word%0d: got v=%b r=%0d x=%h want v=1 r=%0d x=%h",
                             s-2, OUT_VALID, OUT_ROUND, OUT_X, exp_round[s-2], 48'(s-1));
                end
            end
        end
        repeat (4) step();
        n_vec++; if (SEQ_ERR !== 1'b1) begin n_err++; $display("FAIL seq_err_sticky: got %b want 1", SEQ_ERR); end
        RST = 1'b1;
        #1;
        n_vec++; if (SEQ_ERR !== 1'b0) begin n_err++; $display("FAIL seq_err_clear: got %b want 0", SEQ_ERR); end
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        OUT_READY = 1'b0;
        drive(1'b1, 32'h0, 48'h0000000000D1, 1'b1);
        step();
        drive(1'b1, 32'h0, 48'h0000000000D2, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        n_vec++; if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0) begin n_err++; $display("FAIL mid_full: got v=%b rdy=%b want v=1 rdy=0", OUT_VALID, IN_READY); end
        #2;
        RST = 1'b1;
        #1;
        n_vec++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || OUT_X !== 48'h0) begin n_err++; $display("FAIL mid_async: got v=%b rdy=%b x=%h want v=0 rdy=1 x=0", OUT_VALID, IN_READY, OUT_X); end
        step();
        RST = 1'b0;
        OUT_READY = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_vec++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL mid_stale%0d: out_valid %b want 0", c, OUT_VALID); end
        end
        drive(1'b1, 32'h0, 48'h0000000000E5, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        step();
        n_vec++;
        if (OUT_VALID !== 1'b1 || OUT_ROUND !== 4'd0 || OUT_X !== 48'hE5 || SEQ_ERR !== 1'b1) begin
            n_err++;
            $display("FAIL mid_next_word: got v=%b r=%0d x=%h err=%b want v=1 r=0 x=e5 err=1",
                     OUT_VALID, OUT_ROUND, OUT_X, SEQ_ERR);
        end
    endtask

    initial begin
        test_reset();
        test_fips_vector();
        test_extremes();
        test_back_to_back();
        test_backpressure();
        test_seq_err();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/des_key_mix.md
DES_KEY_MIX -- requirements
Module: des_key_mix

Interface
REQ-001 The module SHALL have parameter NUM_ROUNDS, default 16, the number of rounds per block; the legal range SHALL be 2..16.
REQ-002 The module SHALL have port CLK, input, 1 bit: the single clock; all flops SHALL be clocked on its rising edge.
REQ-003 The module SHALL have port RST, input, 1 bit: the reset, which SHALL be asynchronous and active-high.
REQ-004 The module SHALL have port IN_VALID, input, 1 bit: the upstream offers a word.
REQ-005 The module SHALL have port IN_READY, output, 1 bit: the block accepts the word this cycle.
REQ-006 The module SHALL have port IN_R, input, [32:1]: the right half-block, with IN_R[32] = FIPS 46-3 bit 1.
REQ-007 The module SHALL have port IN_K, input, [48:1]: the round subkey, with IN_K[48] = FIPS bit 1.
REQ-008 The module SHALL have port IN_FIRST, input, 1 bit: the word is round 0 of a new block.
REQ-009 The module SHALL have port OUT_VALID, output, 1 bit: OUT_X, OUT_ROUND and OUT_LAST are valid.
REQ-010 The module SHALL have port OUT_READY, input, 1 bit: the downstream S-box stage accepts the word.
REQ-011 The module SHALL have port OUT_X, output, [48:1]: E(R) XOR K; OUT_X[48:43] SHALL feed S1, [42:37] S2, and so on down to [6:1] feeding S8, with bit 6 of each group = FIPS group bit 1.
REQ-012 The module SHALL have port OUT_ROUND, output, [3:0]: the round index 0..NUM_ROUNDS-1 of the word on OUT_X.
REQ-013 The module SHALL have port OUT_LAST, output, 1 bit: high when OUT_ROUND == NUM_ROUNDS-1.
REQ-014 The module SHALL have port SEQ_ERR, output, 1 bit: sticky sequencing-error flag.

Function
REQ-015 A word SHALL be accepted on a rising CLK edge where IN_VALID && IN_READY; it SHALL be delivered on an edge where OUT_VALID && OUT_READY.
REQ-016 The expansion SHALL be the FIPS 46-3 table E (32->48) applied to IN_R, bitwise XORed with IN_K; the datapath SHALL contain no arithmetic and no carries.
REQ-017 The pipeline SHALL have two register stages: stage A holds the XOR result plus its round tag, and stage B drives OUT_X, OUT_ROUND and OUT_LAST.
REQ-018 Latency SHALL be 2 cycles from acceptance to OUT_VALID when OUT_READY is held high.
REQ-019 Throughput SHALL be one word per cycle when OUT_READY is held high.
REQ-020 Stage B SHALL load when it is empty or is being delivered in the same cycle.
REQ-021 Stage A SHALL load when it is empty or is moving to B in the same cycle.
REQ-022 IN_READY SHALL equal !A_valid || !B_valid || OUT_READY, combinationally; it SHALL be the only combinational path from an input to an output.
REQ-023 While OUT_VALID is high and OUT_READY is low, OUT_X, OUT_ROUND and OUT_LAST SHALL hold stable.
REQ-024 No word SHALL be dropped or duplicated under any IN_VALID/OUT_READY pattern.
REQ-025 Simultaneous accept and deliver in one cycle SHALL keep both stages full with data advancing one stage.
REQ-026 The round counter RC SHALL be a 4-bit register of the next round tag; each accepted word SHALL be tagged with RC, or with 0 if IN_FIRST is set.
REQ-027 After each accepted word, RC SHALL become the tag + 1; when the tag == NUM_ROUNDS-1 it SHALL wrap to 0.
REQ-028 SEQ_ERR SHALL be set on acceptance of a word with IN_FIRST = 1 while RC != 0, and on acceptance of a word with IN_FIRST = 0 while RC == 0; such a word SHALL still be processed as tagged.
REQ-029 SEQ_ERR SHALL clear only on RST.
REQ-030 IN_R, IN_K and IN_FIRST SHALL be ignored whenever IN_VALID is low.
REQ-031 Offered words SHALL stay pending and not be accepted while IN_READY is low.

Reset
REQ-032 While RST is high, OUT_VALID, A_valid and B_valid SHALL be 0 asynchronously.
REQ-033 While RST is high, OUT_X SHALL be 48'h0, OUT_ROUND SHALL be 0, OUT_LAST SHALL be 0, SEQ_ERR SHALL be 0 and RC SHALL be 0.
REQ-034 IN_READY SHALL be 1 while RST is high.
REQ-035 RST asserted mid-operation SHALL discard all in-flight words.
REQ-036 The first accepted word after RST deasserts SHALL be tagged round 0.

Verification
REQ-037 The bench SHALL cover: IN_R = 32'hF0AAF0AA, IN_K = 48'h1B02EFFC7072, IN_FIRST = 1 -> 2 cycles later OUT_X = 48'h6117BA866527, OUT_X[42:37] = 6'b010001, OUT_ROUND = 0.
REQ-038 The bench SHALL cover: IN_R = 32'hFFFFFFFF with IN_K = 0, then IN_R = 0 with IN_K = 48'hFFFFFFFFFFFF -> OUT_X = 48'hFFFFFFFFFFFF twice.
REQ-039 The bench SHALL cover: 16 back-to-back words with IN_FIRST on the first only and OUT_READY = 1 -> OUT_ROUND = 0..15 on consecutive cycles, OUT_LAST only on 15, SEQ_ERR = 0.
REQ-040 The bench SHALL cover: OUT_READY = 0 while 3 words are offered -> 2 are accepted, then IN_READY = 0 and outputs are stable; after OUT_READY = 1, all 3 are delivered in order.
REQ-041 The bench SHALL cover: IN_FIRST = 1 on the 5th word of a block -> that word has OUT_ROUND = 0 and SEQ_ERR = 1, held until RST.
REQ-042 The bench SHALL cover: RST pulsed with both stages full -> OUT_VALID = 0 immediately, no stale word afterwards, and the next word is tagged round 0.
